// File: rtl/instr_decode_stage.sv
// Decode stage: assembles 16-bit halfwords into decoded records and buffers them in an output FIFO.
// Define INSTR_DECODE_STATS_EN to add saturating record/unknown counters as extra outputs.
module instr_decode_stage #(
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned REG_IDX_W = 4,
  parameter int unsigned OP_W      = 6,
  parameter int unsigned IMM_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_group,
  output logic [OP_W-1:0]      out_opcode,
  output logic [REG_IDX_W-1:0] out_ra_index,
  output logic [REG_IDX_W-1:0] out_rb_index,
  output logic [REG_IDX_W-1:0] out_rc_index,
  output logic                 out_ra_pair,
  output logic                 out_rb_pair,
  output logic [IMM_W-1:0]     out_imm,
  output logic                 out_long
`ifdef INSTR_DECODE_STATS_EN
  ,
  output logic [15:0]          stat_instr_cnt,
  output logic [15:0]          stat_unknown_cnt
`endif
);

  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(OUT_DEPTH);

  typedef enum logic {S_HI, S_LO} state_t;

  typedef struct packed {
    logic [2:0]           group;
    logic [OP_W-1:0]      opcode;
    logic [REG_IDX_W-1:0] ra;
    logic [REG_IDX_W-1:0] rb;
    logic [REG_IDX_W-1:0] rc;
    logic                 ra_pair;
    logic                 rb_pair;
    logic [IMM_W-1:0]     imm;
    logic                 is_long;
  } rec_t;

  state_t         state_q;
  logic [2:0]     lat_op_q;
  logic [3:0]     lat_ra_q;
  logic [2:0]     lat_rb_q;

  rec_t           mem_q [OUT_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0]   count_q, count_d;

  rec_t rec_d;
  logic is_g5, accept, push, pop;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push      = accept && !flush && !(state_q == S_HI && is_g5);

  always_comb begin
    rec_d = '0;
    is_g5 = 1'b0;
    if (state_q == S_LO) begin
      rec_d.group   = 3'd5;
      rec_d.opcode  = OP_W'(lat_op_q);
      rec_d.ra_pair = lat_op_q[2];
      rec_d.ra      = REG_IDX_W'(lat_op_q[2] ? {1'b0, lat_ra_q[3:1]} : lat_ra_q);
      rec_d.rb      = REG_IDX_W'(lat_rb_q);
      rec_d.imm     = IMM_W'(in_word);
      rec_d.is_long = 1'b1;
    end else if (!in_word[15]) begin
      rec_d.group   = 3'd1;
      rec_d.opcode  = OP_W'(in_word[14:12]);
      rec_d.ra_pair = &in_word[14:12];
      rec_d.ra      = REG_IDX_W'(rec_d.ra_pair ? {1'b0, in_word[11:9]} : in_word[11:8]);
      rec_d.imm     = IMM_W'(in_word[7:0]);
    end else if (in_word[15:14] == 2'b10) begin
      rec_d.group   = 3'd2;
      rec_d.opcode  = OP_W'(in_word[13:8]);
      rec_d.ra_pair = in_word[13];
      rec_d.rb_pair = in_word[12];
      rec_d.ra      = REG_IDX_W'(in_word[13] ? {1'b0, in_word[7:5]} : in_word[7:4]);
      rec_d.rb      = REG_IDX_W'(in_word[12] ? {1'b0, in_word[3:1]} : in_word[3:0]);
    end else if (in_word[15:12] == 4'b1100) begin
      rec_d.group   = 3'd3;
      rec_d.opcode  = OP_W'(in_word[11:10]);
      rec_d.ra      = REG_IDX_W'(in_word[9:6]);
      rec_d.rb      = REG_IDX_W'(in_word[5:3]);
      rec_d.rc      = REG_IDX_W'(in_word[2:0]);
    end else if (in_word[15:12] == 4'b1101) begin
      rec_d.group   = 3'd4;
      rec_d.opcode  = OP_W'(in_word[11:8]);
      rec_d.imm     = IMM_W'(in_word[7:0]);
    end else if (in_word[15:10] == 6'b111000) begin
      is_g5 = 1'b1;
    end
  end

  // First half of a long instruction only latches its fields; the record is built on the second word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HI;
      lat_op_q <= '0;
      lat_ra_q <= '0;
      lat_rb_q <= '0;
    end else if (flush) begin
      state_q <= S_HI;
    end else if (accept) begin
      if (state_q == S_HI && is_g5) begin
        state_q  <= S_LO;
        lat_op_q <= in_word[9:7];
        lat_ra_q <= in_word[6:3];
        lat_rb_q <= in_word[2:0];
      end else begin
        state_q <= S_HI;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= rec_d;
  end

  // Head is masked while empty so stale or uninitialised entries never reach the outputs.
  always_comb begin
    rec_t head;
    head = out_valid ? mem_q[rd_q] : '0;
    out_group    = head.group;
    out_opcode   = head.opcode;
    out_ra_index = head.ra;
    out_rb_index = head.rb;
    out_rc_index = head.rc;
    out_ra_pair  = head.ra_pair;
    out_rb_pair  = head.rb_pair;
    out_imm      = head.imm;
    out_long     = head.is_long;
  end

`ifdef INSTR_DECODE_STATS_EN
  logic [15:0] stat_instr_q, stat_unknown_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_instr_q   <= '0;
      stat_unknown_q <= '0;
    end else if (push) begin
      if (stat_instr_q != '1) stat_instr_q <= stat_instr_q + 1'b1;
      if (rec_d.group == 3'd0 && stat_unknown_q != '1) stat_unknown_q <= stat_unknown_q + 1'b1;
    end
  end

  assign stat_instr_cnt   = stat_instr_q;
  assign stat_unknown_cnt = stat_unknown_q;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage (FIFO depth 2) with hand-computed decoded records.
module tb_instr_decode_stage;
  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_word;
  logic [2:0]  out_group;
  logic [5:0]  out_opcode;
  logic [3:0]  out_ra_index, out_rb_index, out_rc_index;
  logic        out_ra_pair, out_rb_pair, out_long;
  logic [15:0] out_imm;
`ifdef INSTR_DECODE_STATS_EN
  logic [15:0] stat_instr_cnt, stat_unknown_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // {valid, group, opcode, ra, rb, rc, ra_pair, rb_pair, imm, long}
  logic [40:0] obs;
  assign obs = {out_valid, out_group, out_opcode, out_ra_index, out_rb_index, out_rc_index,
                out_ra_pair, out_rb_pair, out_imm, out_long};

  instr_decode_stage #(.OUT_DEPTH(2), .REG_IDX_W(4), .OP_W(6), .IMM_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_group(out_group), .out_opcode(out_opcode),
    .out_ra_index(out_ra_index), .out_rb_index(out_rb_index), .out_rc_index(out_rc_index),
    .out_ra_pair(out_ra_pair), .out_rb_pair(out_rb_pair),
    .out_imm(out_imm), .out_long(out_long)
`ifdef INSTR_DECODE_STATS_EN
    , .stat_instr_cnt(stat_instr_cnt), .stat_unknown_cnt(stat_unknown_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (obs !== 41'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs got %h rdy %b exp 0 rdy 1", obs, in_ready);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== 41'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle got %h rdy %b exp 0 rdy 1", obs, in_ready);
    end
  endtask

  task automatic test_g1();
    out_ready = 1'b1;
    in_word = 16'h3A5C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd1, 6'd3, 4'hA, 4'd0, 4'd0, 1'b0, 1'b0, 16'h005C, 1'b0}) begin
      errors++;
      $display("FAIL g1_3A5C got %h", obs);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL g1_popped got valid %b exp 0", out_valid);
    end
  endtask

  task automatic test_g2_pair();
    in_word = 16'h9E12; in_valid = 1'b1;
    step();
    checks++;
    if (obs !== {1'b1, 3'd2, 6'h1E, 4'd1, 4'd1, 4'd0, 1'b0, 1'b1, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL g2_9E12 got %h", obs);
    end
    in_word = 16'hA076;
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd2, 6'h20, 4'd3, 4'd6, 4'd0, 1'b1, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL g2_A076 got %h", obs);
    end
    step();
  endtask

  task automatic test_g3_g4();
    in_word = 16'hCABC; in_valid = 1'b1;
    step();
    checks++;
    if (obs !== {1'b1, 3'd3, 6'd2, 4'hA, 4'd7, 4'd4, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL g3_CABC got %h", obs);
    end
    in_word = 16'hD7F0;
    step();
    checks++;
    if (obs !== {1'b1, 3'd4, 6'd7, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h00F0, 1'b0}) begin
      errors++;
      $display("FAIL g4_D7F0 got %h", obs);
    end
    in_word = 16'h7B34;
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd1, 6'd7, 4'd5, 4'd0, 4'd0, 1'b1, 1'b0, 16'h0034, 1'b0}) begin
      errors++;
      $display("FAIL g1_pair_7B34 got %h", obs);
    end
    step();
  endtask

  task automatic test_g5_long();
    in_word = 16'hE1AB; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL g5_no_early_record idle %0d got valid %b exp 0", i, out_valid);
      end
      if (i < 2) step();
    end
    step();
    in_word = 16'h1234; in_valid = 1'b1;
    step();
    checks++;
    if (obs !== {1'b1, 3'd5, 6'd3, 4'd5, 4'd3, 4'd0, 1'b0, 1'b0, 16'h1234, 1'b1}) begin
      errors++;
      $display("FAIL g5_E1AB_1234 got %h", obs);
    end
    in_word = 16'hE3B5;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL g5_second_first_half got valid %b exp 0", out_valid);
    end
    in_word = 16'hBEEF;
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd5, 6'd7, 4'd3, 4'd5, 4'd0, 1'b1, 1'b0, 16'hBEEF, 1'b1}) begin
      errors++;
      $display("FAIL g5_pair_E3B5_BEEF got %h", obs);
    end
    step();
  endtask

  task automatic test_unknown();
`ifdef INSTR_DECODE_STATS_EN
    logic [15:0] unk_before;
    unk_before = stat_unknown_cnt;
`endif
    in_word = 16'hF000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 40'd0}) begin
      errors++;
      $display("FAIL unknown_F000 got %h", obs);
    end
`ifdef INSTR_DECODE_STATS_EN
    checks++;
    if (stat_unknown_cnt !== unk_before + 16'd1) begin
      errors++;
      $display("FAIL stat_unknown got %0d exp %0d", stat_unknown_cnt, unk_before + 16'd1);
    end
`endif
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_word = 16'h1001; in_valid = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_after_one got %b exp 1", in_ready);
    end
    in_word = 16'h1002;
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_after_two got %b exp 0", in_ready);
    end
    in_word = 16'h1003;
    step();
    checks++;
    if (in_ready !== 1'b0 || obs !== {1'b1, 3'd1, 6'd1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0001, 1'b0}) begin
      errors++;
      $display("FAIL bp_hold_head1 got %h rdy %b", obs, in_ready);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_imm !== 16'h0002 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_head2 got imm %h valid %b rdy %b exp 0002 1 1", out_imm, out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_imm !== 16'h0003 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_head3 got imm %h valid %b exp 0003 1", out_imm, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained got valid %b exp 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_word = 16'hE1AB; in_valid = 1'b1;
    step();
    flush = 1'b1; in_word = 16'h1234;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_mid_long got valid %b exp 0", out_valid);
    end
    in_word = 16'h3A5C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd1, 6'd3, 4'hA, 4'd0, 4'd0, 1'b0, 1'b0, 16'h005C, 1'b0}) begin
      errors++;
      $display("FAIL flush_then_g1 got %h", obs);
    end
    step();
    out_ready = 1'b0;
    in_word = 16'h1005; in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full_fifo got valid %b rdy %b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_long();
    out_ready = 1'b1;
    in_word = 16'hE1AB; in_valid = 1'b1;
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 41'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async got %h rdy %b exp 0 1", obs, in_ready);
    end
    #1 rst_n = 1'b1;
    in_word = 16'h9E12; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 3'd2, 6'h1E, 4'd1, 4'd1, 4'd0, 1'b0, 1'b1, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_long_discard got %h", obs);
    end
    step();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    repeat (2) step();
    test_reset();
    test_g1();
    test_g2_pair();
    test_g3_g4();
    test_g5_long();
    test_unknown();
    test_backpressure();
    test_flush();
    test_reset_mid_long();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
